bram_decode_write: RTL and testbench
====================================

Name: bram_decode_write

Overview:
- Write-back address/data router for the 8-butterfly NTT datapath.
- Keeps a copy of the per-lane core addresses issued on the read side. Delays them by the butterfly pipeline depth.
- Splits each address into bank index and row, for both the A (addr) and B (addr+olen) operands.
- Steers butterfly results into the 8 dual-port coefficient BRAMs through an 8x8 write crossbar. Tracks drain and signals write-phase completion.

Parameters:
DATA_WIDTH, 12, coefficient width
ADW, 5, BRAM row address width (32 rows x 8 banks = 256 coefficients)
BU_LAT, 4, cycles from addr_valid_i to butterfly result valid (BRAM read + BU pipeline), range 1..15

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
start_write_i  in  1  one-cycle pulse, arms a new stage write-back
addr_valid_i  in  1  lane addresses on addr_core_i valid this cycle
addr_core_i  in  64  8 lanes x 8-bit core address of operand A, lane i at [8i+7:8i]
olen_i  in  8  butterfly half-length for current stage
done_read_i  in  1  one-cycle pulse, last read address issued
bu_a_i  in  8*DATA_WIDTH  butterfly A results, lane i at [DATA_WIDTH*i +: DATA_WIDTH]
bu_b_i  in  8*DATA_WIDTH  butterfly B results, same packing
wr_addr_a_o  out  8*ADW  per-bank port-A row address, bank k at [ADW*k +: ADW]
wr_data_a_o  out  8*DATA_WIDTH  per-bank port-A write data
wr_en_a_o  out  8  per-bank port-A write enable
wr_addr_b_o  out  8*ADW  per-bank port-B row address
wr_data_b_o  out  8*DATA_WIDTH  per-bank port-B write data
wr_en_b_o  out  8  per-bank port-B write enable
busy_o  out  1  FSM not IDLE
conflict_o  out  1  sticky: two lanes hit the same bank/port in one cycle
done_write_o  out  1  one-cycle pulse, all write-backs issued

Behaviour:
- Reset (rst_i=0, async): all outputs 0, delay line cleared, FSM=IDLE. Reset mid-operation aborts; no write enables asserted afterwards until a new start_write_i.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN on start_write_i.
  - RUN -> DRAIN on done_read_i.
  - DRAIN counts BU_LAT+1 cycles, including the cycle after done_read_i, then -> DONE.
  - DONE -> IDLE unconditionally, asserting done_write_o for exactly that one cycle.
  - start_write_i outside IDLE is ignored.
  - addr_valid_i in IDLE is ignored (not captured).
  - done_read_i together with addr_valid_i in RUN: the address is captured, then DRAIN begins.
- Delay line: BU_LAT-deep shift of {valid, addr_core[63:0], olen[7:0]}. Shifts every cycle with no stall.
- Decode at the delay-line tail:
  - addrA_i = addr_core lane i.
  - addrB_i = addrA_i + olen, truncated to 8 bits (wraps mod 256).
  - bank = [7:5], row = [4:0].
- bu_a_i/bu_b_i are sampled in the same cycle the tail entry is valid, i.e. BU_LAT cycles after its addr_valid_i.
- Crossbar, port A: for each bank k, select the lowest lane i with bankA_i==k.
  - wr_en_a[k]=1, wr_addr_a[k]=rowA_i, wr_data_a[k]=bu_a lane i.
  - No lane selecting bank k: wr_en_a[k]=0, addr/data 0.
- Crossbar, port B: identical, using addrB and bu_b.
- Output stage is registered. Write enables appear BU_LAT+1 cycles after the matching addr_valid_i.
- Conflicts:
  - Two or more valid lanes with the same bank on the same port: lowest lane wins and conflict_o sets.
  - conflict_o clears only on reset or start_write_i.
  - The A-vs-B same bank case uses separate ports and is not a conflict.
- Invalid tail entry: all write enables 0 that cycle.
- Throughput: one full 8-lane write-back (16 writes) per cycle.

Test Plan:
- Reset: hold rst_i=0 with nonzero inputs -> all outputs 0. Release, then drive addr_valid_i in IDLE -> no wr_en ever.
- Single beat, olen=128, lanes addr=i*4 (0,4,...,28), bu_a lane i=0x100+i, bu_b=0x200+i.
  - Expected exactly 5 cycles after valid: wr_en_a=0x01 with row from lane 0 (all lanes hit bank 0 port A, so conflict_o=1).
  - Expected port B: bank 4 written (addr 128), data 0x200.
- Conflict-free stage, olen=16, lane i addr=32*i:
  - wr_en_a=0xFF, wr_addr_a[k]=0, wr_data_a[k]=bu_a lane k.
  - wr_addr_b[k]=16, conflict_o=0.
- Wrap-around: addr=240, olen=32 -> B address 16: bank 0, row 16.
- Streaming 16 consecutive beats then done_read_i with the last beat:
  - 16 consecutive write cycles.
  - done_write_o pulses exactly BU_LAT+2 cycles after done_read_i.
  - busy_o low the cycle after.
- Reset asserted during DRAIN -> outputs drop to 0 asynchronously, no done_write_o. A new start_write_i works normally.

Source files
------------

// File: rtl/bram_decode_write.sv
// rtl/bram_decode_write.sv - NTT write-back router: address delay line, bank/row decode, 8x8 write crossbar
module bram_decode_write #(
    parameter int DATA_WIDTH = 12,
    parameter int ADW        = 5,
    parameter int BU_LAT     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_write_i,
    input  logic                    addr_valid_i,
    input  logic [63:0]             addr_core_i,
    input  logic [7:0]              olen_i,
    input  logic                    done_read_i,
    input  logic [8*DATA_WIDTH-1:0] bu_a_i,
    input  logic [8*DATA_WIDTH-1:0] bu_b_i,
    output logic [8*ADW-1:0]        wr_addr_a_o,
    output logic [8*DATA_WIDTH-1:0] wr_data_a_o,
    output logic [7:0]              wr_en_a_o,
    output logic [8*ADW-1:0]        wr_addr_b_o,
    output logic [8*DATA_WIDTH-1:0] wr_data_b_o,
    output logic [7:0]              wr_en_b_o,
    output logic                    busy_o,
    output logic                    conflict_o,
    output logic                    done_write_o
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic            dl_valid [BU_LAT];
    logic [63:0]     dl_addr  [BU_LAT];
    logic [7:0]      dl_olen  [BU_LAT];

    logic            tail_valid;
    logic [63:0]     tail_addr;
    logic [7:0]      tail_olen;

    logic [7:0]      lane_a [8];
    logic [7:0]      lane_b [8];
    logic [7:0]      hit_a  [8];
    logic [7:0]      hit_b  [8];

    logic [7:0]              nxt_en_a;
    logic [7:0]              nxt_en_b;
    logic [8*ADW-1:0]        nxt_addr_a;
    logic [8*ADW-1:0]        nxt_addr_b;
    logic [8*DATA_WIDTH-1:0] nxt_data_a;
    logic [8*DATA_WIDTH-1:0] nxt_data_b;
    logic                    nxt_conflict;

    // Stage control: IDLE -> RUN -> DRAIN (BU_LAT+1 cycles) -> DONE -> IDLE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy_o       <= 1'b0;
            done_write_o <= 1'b0;
        end else begin
            done_write_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_write_i) begin
                        state  <= S_RUN;
                        busy_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (done_read_i) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(BU_LAT)) begin
                        state        <= S_DONE;
                        done_write_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address delay line matching the BRAM read + butterfly latency; only RUN-state addresses are marked valid
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int j = 0; j < BU_LAT; j++) begin
                dl_valid[j] <= 1'b0;
                dl_addr[j]  <= '0;
                dl_olen[j]  <= '0;
            end
        end else begin
            dl_valid[0] <= addr_valid_i && (state == S_RUN);
            dl_addr[0]  <= addr_core_i;
            dl_olen[0]  <= olen_i;
            for (int j = 1; j < BU_LAT; j++) begin
                dl_valid[j] <= dl_valid[j-1];
                dl_addr[j]  <= dl_addr[j-1];
                dl_olen[j]  <= dl_olen[j-1];
            end
        end
    end

    assign tail_valid = dl_valid[BU_LAT-1];
    assign tail_addr  = dl_addr[BU_LAT-1];
    assign tail_olen  = dl_olen[BU_LAT-1];

    // Per-lane operand addresses and the bank-hit matrix hit_x[bank][lane]
    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign lane_a[i] = tail_addr[8*i +: 8];
        assign lane_b[i] = lane_a[i] + tail_olen;
        for (genvar k = 0; k < 8; k++) begin : g_bank
            assign hit_a[k][i] = tail_valid && (lane_a[i][7:5] == 3'(k));
            assign hit_b[k][i] = tail_valid && (lane_b[i][7:5] == 3'(k));
        end
    end

    // Crossbar: lowest hitting lane owns each bank port; more than one hit flags a conflict
    always_comb begin
        nxt_en_a     = '0;
        nxt_en_b     = '0;
        nxt_addr_a   = '0;
        nxt_addr_b   = '0;
        nxt_data_a   = '0;
        nxt_data_b   = '0;
        nxt_conflict = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 7; i >= 0; i--) begin
                if (hit_a[k][i]) begin
                    nxt_en_a[k]                          = 1'b1;
                    nxt_addr_a[ADW*k +: ADW]             = ADW'(lane_a[i][4:0]);
                    nxt_data_a[DATA_WIDTH*k +: DATA_WIDTH] = bu_a_i[DATA_WIDTH*i +: DATA_WIDTH];
                end
                if (hit_b[k][i]) begin
                    nxt_en_b[k]                          = 1'b1;
                    nxt_addr_b[ADW*k +: ADW]             = ADW'(lane_b[i][4:0]);
                    nxt_data_b[DATA_WIDTH*k +: DATA_WIDTH] = bu_b_i[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
            if (((hit_a[k] & (hit_a[k] - 8'd1)) != 8'd0) ||
                ((hit_b[k] & (hit_b[k] - 8'd1)) != 8'd0)) begin
                nxt_conflict = 1'b1;
            end
        end
    end

    // Registered write ports; conflict is sticky until an accepted start
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_en_a_o   <= '0;
            wr_en_b_o   <= '0;
            wr_addr_a_o <= '0;
            wr_addr_b_o <= '0;
            wr_data_a_o <= '0;
            wr_data_b_o <= '0;
            conflict_o  <= 1'b0;
        end else begin
            wr_en_a_o   <= nxt_en_a;
            wr_en_b_o   <= nxt_en_b;
            wr_addr_a_o <= nxt_addr_a;
            wr_addr_b_o <= nxt_addr_b;
            wr_data_a_o <= nxt_data_a;
            wr_data_b_o <= nxt_data_b;
            conflict_o  <= nxt_conflict ||
                           (conflict_o && !(start_write_i && (state == S_IDLE)));
        end
    end

endmodule

// File: tb/tb_bram_decode_write.sv
// tb/tb_bram_decode_write.sv - scoreboard bench for bram_decode_write
module tb_bram_decode_write;

    localparam int DW  = 12;
    localparam int ADW = 5;
    localparam int BL  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_write_i;
    logic              addr_valid_i;
    logic [63:0]       addr_core_i;
    logic [7:0]        olen_i;
    logic              done_read_i;
    logic [8*DW-1:0]   bu_a_i;
    logic [8*DW-1:0]   bu_b_i;
    logic [8*ADW-1:0]  wr_addr_a_o;
    logic [8*DW-1:0]   wr_data_a_o;
    logic [7:0]        wr_en_a_o;
    logic [8*ADW-1:0]  wr_addr_b_o;
    logic [8*DW-1:0]   wr_data_b_o;
    logic [7:0]        wr_en_b_o;
    logic              busy_o;
    logic              conflict_o;
    logic              done_write_o;

    always #5 clk_i = ~clk_i;

    bram_decode_write #(.DATA_WIDTH(DW), .ADW(ADW), .BU_LAT(BL)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .start_write_i(start_write_i), .addr_valid_i(addr_valid_i),
        .addr_core_i(addr_core_i), .olen_i(olen_i), .done_read_i(done_read_i),
        .bu_a_i(bu_a_i), .bu_b_i(bu_b_i),
        .wr_addr_a_o(wr_addr_a_o), .wr_data_a_o(wr_data_a_o), .wr_en_a_o(wr_en_a_o),
        .wr_addr_b_o(wr_addr_b_o), .wr_data_b_o(wr_data_b_o), .wr_en_b_o(wr_en_b_o),
        .busy_o(busy_o), .conflict_o(conflict_o), .done_write_o(done_write_o)
    );

    typedef struct {
        int               due;
        logic [7:0]       en_a;
        logic [7:0]       en_b;
        logic [8*ADW-1:0] addr_a;
        logic [8*ADW-1:0] addr_b;
        logic [8*DW-1:0]  data_a;
        logic [8*DW-1:0]  data_b;
    } exp_t;

    typedef struct {
        int              due;
        logic [8*DW-1:0] a;
        logic [8*DW-1:0] b;
    } bu_t;

    exp_t exp_q[$];
    bu_t  bu_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},   {wr_en_a_o, wr_en_b_o}, 128'h0);
        check({tag, "_addr"}, {wr_addr_a_o, wr_addr_b_o}, 128'h0);
        check({tag, "_data"}, {wr_data_a_o, wr_data_b_o}, 128'h0);
        check({tag, "_flags"}, {busy_o, conflict_o, done_write_o}, 128'h0);
    endtask

    // Advance one cycle, compare against the scoreboard, then drive default/bu inputs
    task automatic tick();
        exp_t e;
        bu_t  u;
        @(posedge clk_i);
        #1;
        cyc++;
        start_write_i = 1'b0;
        addr_valid_i  = 1'b0;
        done_read_i   = 1'b0;
        addr_core_i   = {$urandom, $urandom};
        olen_i        = 8'($urandom);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("en_a",   wr_en_a_o,   e.en_a);
            check("en_b",   wr_en_b_o,   e.en_b);
            check("addr_a", wr_addr_a_o, e.addr_a);
            check("addr_b", wr_addr_b_o, e.addr_b);
            check("data_a", wr_data_a_o, e.data_a);
            check("data_b", wr_data_b_o, e.data_b);
        end else begin
            check("idle_en", {wr_en_a_o, wr_en_b_o}, 128'h0);
        end
        if (bu_q.size() > 0 && bu_q[0].due == cyc) begin
            u = bu_q.pop_front();
            bu_a_i = u.a;
            bu_b_i = u.b;
        end else begin
            bu_a_i = {$urandom, $urandom, $urandom};
            bu_b_i = {$urandom, $urandom, $urandom};
        end
    endtask

    // Drive one address beat this cycle and record expected write-back (first lane claiming a bank wins)
    task automatic beat(input logic [63:0] addr, input logic [7:0] olen,
                        input logic [8*DW-1:0] a, input logic [8*DW-1:0] b);
        exp_t       e;
        bu_t        u;
        logic [7:0] aa;
        logic [7:0] bb;
        int         bk;
        addr_valid_i = 1'b1;
        addr_core_i  = addr;
        olen_i       = olen;
        u.due = cyc + BL;
        u.a   = a;
        u.b   = b;
        bu_q.push_back(u);
        e.due = cyc + BL + 1;
        e.en_a = '0; e.en_b = '0;
        e.addr_a = '0; e.addr_b = '0;
        e.data_a = '0; e.data_b = '0;
        for (int i = 0; i < 8; i++) begin
            aa = addr[8*i +: 8];
            bb = aa + olen;
            bk = int'(aa[7:5]);
            if (!e.en_a[bk]) begin
                e.en_a[bk] = 1'b1;
                e.addr_a[ADW*bk +: ADW] = aa[4:0];
                e.data_a[DW*bk +: DW]   = a[DW*i +: DW];
            end
            bk = int'(bb[7:5]);
            if (!e.en_b[bk]) begin
                e.en_b[bk] = 1'b1;
                e.addr_b[ADW*bk +: ADW] = bb[4:0];
                e.data_b[DW*bk +: DW]   = b[DW*i +: DW];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic start_stage();
        tick();
        start_write_i = 1'b1;
        tick();
        check("busy_run", busy_o, 1'b1);
        check("conflict_cleared", conflict_o, 1'b0);
    endtask

    task automatic wait_done(input int d);
        while (cyc < d + BL + 2) begin
            tick();
            if (cyc < d + BL + 2) check("done_early", done_write_o, 1'b0);
        end
        check("done_pulse", done_write_o, 1'b1);
        check("busy_in_done", busy_o, 1'b1);
        tick();
        check("done_clear", done_write_o, 1'b0);
        check("busy_after", busy_o, 1'b0);
    endtask

    function automatic logic [8*DW-1:0] lanes(input logic [11:0] base);
        logic [8*DW-1:0] v;
        for (int i = 0; i < 8; i++) v[DW*i +: DW] = base + 12'(i);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] addr;
        int          d;

        // Reset held with busy inputs
        rst_i         = 1'b0;
        start_write_i = 1'b1;
        addr_valid_i  = 1'b1;
        done_read_i   = 1'b1;
        addr_core_i   = 64'h0123_4567_89AB_CDEF;
        olen_i        = 8'h55;
        bu_a_i        = {$urandom, $urandom, $urandom};
        bu_b_i        = {$urandom, $urandom, $urandom};
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        start_write_i = 1'b0;
        done_read_i   = 1'b0;
        #3 rst_i = 1'b1;

        // addr_valid in IDLE never produces writes
        for (int n = 0; n < BL + 4; n++) begin
            tick();
            addr_valid_i = 1'b1;
        end
        tick();
        check("idle_busy", busy_o, 1'b0);

        // Single beat, everything on bank 0 port A and bank 4 port B
        start_stage();
        for (int i = 0; i < 8; i++) addr[8*i +: 8] = 8'(4 * i);
        beat(addr, 8'd128, lanes(12'h100), lanes(12'h200));
        done_read_i = 1'b1;
        d = cyc;
        wait_done(d);
        check("single_en_a", wr_en_a_o, 8'h00);
        check("single_conflict", conflict_o, 1'b1);

        // Conflict-free beat followed by a wrapping beat
        start_stage();
        for (int i = 0; i < 8; i++) addr[8*i +: 8] = 8'(32 * i);
        beat(addr, 8'd16, lanes(12'h300), lanes(12'h400));
        tick();
        for (int i = 0; i < 8; i++) addr[8*i +: 8] = 8'(32 * i + 16);
        beat(addr, 8'd32, lanes(12'h500), lanes(12'h600));
        done_read_i = 1'b1;
        d = cyc;
        wait_done(d);
        check("clean_conflict", conflict_o, 1'b0);

        // Sixteen back-to-back beats, done_read with the last
        start_stage();
        for (int b = 0; b < 16; b++) begin
            if (b > 0) tick();
            beat({$urandom, $urandom}, 8'($urandom),
                 {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
            if (b == 15) begin
                done_read_i = 1'b1;
                d = cyc;
            end
        end
        wait_done(d);

        // Reset in DRAIN while writes are in flight
        start_stage();
        d = cyc;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) tick();
            for (int i = 0; i < 8; i++) addr[8*i +: 8] = 8'(32 * i + b);
            beat(addr, 8'd16, lanes(12'h700), lanes(12'h800));
            if (b == 2) done_read_i = 1'b1;
        end
        while (cyc < d + BL + 1) tick();
        check("pre_reset_en", wr_en_a_o, 8'hFF);
        #3 rst_i = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        bu_q.delete();
        tick();
        #2 rst_i = 1'b1;
        for (int n = 0; n < BL + 4; n++) begin
            tick();
            check("no_done_after_reset", {busy_o, done_write_o}, 2'b00);
        end

        // Normal stage after the abort
        start_stage();
        for (int i = 0; i < 8; i++) addr[8*i +: 8] = 8'(32 * i + 3);
        beat(addr, 8'd16, lanes(12'h900), lanes(12'hA00));
        done_read_i = 1'b1;
        d = cyc;
        wait_done(d);
        check("final_conflict", conflict_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
